usbeps_byte_packer: RTL and testbench
=====================================

// Module: usbeps_byte_packer
// PURPOSE
//  Upstream feeder of the USB endpoint -> AL-bus command bridge. Packs the 8-bit USB OUT endpoint
//  byte stream into little-endian 32-bit AXIS words with keep/last, ready for the bridge's s_axis_endpoint_tx_*.
//  Sustains 1 byte/clk. Holds off a new packet while the bridge reports busy. Counts emitted packets.
// PARAMETERS
//  GATE_ON_BUSY  1  1: a new packet's first byte is not accepted while m_axis_endpoint_tx_busy=1; 0: busy ignored
//  PKT_CNT_W     16 width of stat_pkt_cnt (wraps)
// PORTS
//  clk                       in  1          clock; all logic on posedge
//  rst                       in  1          asynchronous, active-high reset
//  s_axis_ep_byte_valid      in  1          byte valid
//  s_axis_ep_byte_ready      out 1          byte accepted when valid&&ready
//  s_axis_ep_byte_data       in  8          byte
//  s_axis_ep_byte_last       in  1          last byte of USB packet
//  m_axis_endpoint_tx_busy   in  1          bridge busy (mid-transaction)
//  m_axis_endpoint_tx_valid  out 1          word valid
//  m_axis_endpoint_tx_ready  in  1          word accepted when valid&&ready
//  m_axis_endpoint_tx_last   out 1          last word of packet
//  m_axis_endpoint_tx_data   out 32         packed word, first byte in [7:0]
//  m_axis_endpoint_tx_keep   out 4          valid byte lanes
//  stat_pkt_cnt              out PKT_CNT_W  packets fully handed to bridge
// BEHAVIOUR
//  - State: acc_data[23:0], acc_cnt[1:0] (bytes held), in_pkt (1 after first byte of a packet until its last byte
//    accepted), output register {valid,data,keep,last}. Reset (async): all zero -> m_*_valid=0, data/keep/last=0,
//    stat_pkt_cnt=0, in_pkt=0, acc_cnt=0. Reset mid-packet discards partial data; no word is emitted for it.
//  - out_free = !m_axis_endpoint_tx_valid || m_axis_endpoint_tx_ready.
//  - gate = GATE_ON_BUSY && !in_pkt && acc_cnt==0 && m_axis_endpoint_tx_busy.
//  - s_axis_ep_byte_ready = !gate && (out_free || (acc_cnt!=3 && !s_axis_ep_byte_last)) (comb.).
//  - Accepted byte with acc_cnt<3 and last=0: stored in lane acc_cnt; acc_cnt++; in_pkt<=1.
//  - Accepted byte completing a word (acc_cnt==3 or last=1): output reg loads next cycle with
//    data={zero-filled upper lanes, byte, acc_data[8*acc_cnt-1:0]}, keep by byte count: 1->0001, 2->0011, 3->0111,
//    4->1111; last=s_last; valid=1; acc_cnt<=0; in_pkt<=!s_last. Unused lanes zero.
//  - Latency: completing byte accepted in cycle N -> word valid in N+1.
//  - Output held stable while valid&&!ready. Valid clears on ready unless a new word loads in the same cycle
//    (back-to-back: load wins, valid stays 1).
//  - stat_pkt_cnt increments (wraps) on each accepted word with last=1.
//  - Throughput: 4 bytes/4 clk continuous with ready=1; no bubbles between packets unless gated.
//  - Busy gate applies only at packet start; busy rising mid-packet never stalls input.
//  - Zero-length packets are not representable on the byte side; none are emitted.
// TESTING
//  1 8 bytes 01..08 last on 08, ready=1 -> words 0x04030201 keep F last0, 0x08070605 keep F last1; cnt=1.
//  2 5 bytes AA..EE -> 0xDDCCBBAA keep F, 0x000000EE keep 1 last1; 1-,2-,3-byte packets -> keep 1/3/7, last1.
//  3 m_ready low 10 cycles mid 12-byte packet -> s_ready drops once acc full; data/keep stable; no loss/dup.
//  4 busy=1 between packets -> next first byte not accepted until busy=0; busy asserted mid-packet -> no stall.
//  5 rst pulse after 2 bytes of a packet -> valid=0, cnt=0; next packet packs from lane 0 cleanly.

Source files
------------

// File: rtl/usbeps_byte_packer.sv
// Packs a USB OUT endpoint byte stream into little-endian 32-bit AXIS words with keep/last.
// A new packet can be held off while the downstream bridge reports busy.
module usbeps_byte_packer #(
  parameter bit GATE_ON_BUSY = 1'b1,
  parameter int PKT_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_ep_byte_valid,
  output logic                 s_axis_ep_byte_ready,
  input  logic [7:0]           s_axis_ep_byte_data,
  input  logic                 s_axis_ep_byte_last,
  input  logic                 m_axis_endpoint_tx_busy,
  output logic                 m_axis_endpoint_tx_valid,
  input  logic                 m_axis_endpoint_tx_ready,
  output logic                 m_axis_endpoint_tx_last,
  output logic [31:0]          m_axis_endpoint_tx_data,
  output logic [3:0]           m_axis_endpoint_tx_keep,
  output logic [PKT_CNT_W-1:0] stat_pkt_cnt
);

  logic [23:0]          acc_data_q, acc_data_d;
  logic [1:0]           acc_cnt_q, acc_cnt_d;
  logic                 in_pkt_q, in_pkt_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q, out_data_d;
  logic [3:0]           out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic out_free, gate, accept, complete;

  assign out_free = !out_valid_q || m_axis_endpoint_tx_ready;
  // Busy only holds off the first byte of a packet; mid-packet bytes always flow.
  assign gate     = GATE_ON_BUSY && !in_pkt_q && (acc_cnt_q == 2'd0) && m_axis_endpoint_tx_busy;
  assign s_axis_ep_byte_ready = !gate &&
                                (out_free || ((acc_cnt_q != 2'd3) && !s_axis_ep_byte_last));
  assign accept   = s_axis_ep_byte_valid && s_axis_ep_byte_ready;
  assign complete = accept && ((acc_cnt_q == 2'd3) || s_axis_ep_byte_last);

  always_comb begin
    acc_data_d  = acc_data_q;
    acc_cnt_d   = acc_cnt_q;
    in_pkt_d    = in_pkt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (out_valid_q && m_axis_endpoint_tx_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    if (complete) begin
      // Load wins over the ready-clear above, so back-to-back words keep valid high.
      out_valid_d = 1'b1;
      out_last_d  = s_axis_ep_byte_last;
      acc_cnt_d   = 2'd0;
      in_pkt_d    = !s_axis_ep_byte_last;
      case (acc_cnt_q)
        2'd0: begin
          out_data_d = {24'h0, s_axis_ep_byte_data};
          out_keep_d = 4'b0001;
        end
        2'd1: begin
          out_data_d = {16'h0, s_axis_ep_byte_data, acc_data_q[7:0]};
          out_keep_d = 4'b0011;
        end
        2'd2: begin
          out_data_d = {8'h0, s_axis_ep_byte_data, acc_data_q[15:0]};
          out_keep_d = 4'b0111;
        end
        default: begin
          out_data_d = {s_axis_ep_byte_data, acc_data_q};
          out_keep_d = 4'b1111;
        end
      endcase
    end else if (accept) begin
      case (acc_cnt_q)
        2'd0:    acc_data_d[7:0]   = s_axis_ep_byte_data;
        2'd1:    acc_data_d[15:8]  = s_axis_ep_byte_data;
        default: acc_data_d[23:16] = s_axis_ep_byte_data;
      endcase
      acc_cnt_d = acc_cnt_q + 2'd1;
      in_pkt_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q  <= '0;
      acc_cnt_q   <= '0;
      in_pkt_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_cnt_q   <= acc_cnt_d;
      in_pkt_q    <= in_pkt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign m_axis_endpoint_tx_valid = out_valid_q;
  assign m_axis_endpoint_tx_data  = out_data_q;
  assign m_axis_endpoint_tx_keep  = out_keep_q;
  assign m_axis_endpoint_tx_last  = out_last_q;
  assign stat_pkt_cnt             = pkt_cnt_q;

endmodule

// File: tb/tb_usbeps_byte_packer.sv
// Directed bench for usbeps_byte_packer: packets are turned into expected words at packet level
// and a per-cycle monitor checks every handshaked word, hold stability and the packet counter.
module tb_usbeps_byte_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h0;
  logic        s_last = 1'b0;
  logic        busy = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] pkt_cnt;

  int    checks = 0;
  int    failures = 0;
  int    exp_cnt = 0;
  word_t exp_q[$];
  word_t log_q[$];
  bit    hold_prev = 1'b0;
  word_t prev_w;

  usbeps_byte_packer #(.GATE_ON_BUSY(1'b1), .PKT_CNT_W(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_ep_byte_valid     (s_valid),
    .s_axis_ep_byte_ready     (s_ready),
    .s_axis_ep_byte_data      (s_data),
    .s_axis_ep_byte_last      (s_last),
    .m_axis_endpoint_tx_busy  (busy),
    .m_axis_endpoint_tx_valid (m_valid),
    .m_axis_endpoint_tx_ready (m_ready),
    .m_axis_endpoint_tx_last  (m_last),
    .m_axis_endpoint_tx_data  (m_data),
    .m_axis_endpoint_tx_keep  (m_keep),
    .stat_pkt_cnt             (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: split the byte list into 4-byte little-endian chunks.
  task automatic model_pkt(input int n, input logic [7:0] first, input logic [7:0] step);
    word_t w;
    int nb;
    for (int b = 0; b < n; b += 4) begin
      nb  = (n - b < 4) ? (n - b) : 4;
      w.d = '0;
      for (int k = 0; k < nb; k++) w.d[8*k +: 8] = first + 8'((b + k) * step);
      w.k = 4'((1 << nb) - 1);
      w.l = (b + 4 >= n);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout: byte 0x%0h not accepted", d);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] first, input logic [7:0] step);
    model_pkt(n, first, step);
    for (int i = 0; i < n; i++) send_byte(first + 8'(i * step), i == n - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: counter, hold stability and word contents on every cycle out of reset.
  always @(negedge clk) begin
    word_t cur, e;
    if (rst) begin
      exp_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      cur = '{d: m_data, k: m_keep, l: m_last};
      check("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt[15:0]));
      if (hold_prev) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_word", 64'(cur), 64'(prev_w));
      end
      if (m_valid && m_ready) begin
        log_q.push_back(cur);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h keep %0h last %0d", m_data, m_keep, m_last);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(m_data), 64'(e.d));
          check("word_keep", 64'(m_keep), 64'(e.k));
          check("word_last", 64'(m_last), 64'(e.l));
        end
        if (m_last) exp_cnt++;
      end
      hold_prev = m_valid && !m_ready;
      prev_w    = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int  base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_keep", 64'(m_keep), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // 1: 8 bytes, continuous rate
    base = log_q.size();
    t0 = $time;
    send_pkt(8, 8'h01, 8'h01);
    check("t1_cycles", 64'(($time - t0) / 10), 64'd8);
    drain();
    check("t1_w0", 64'(log_q[base]), 64'({32'h04030201, 4'hF, 1'b0}));
    check("t1_w1", 64'(log_q[base+1]), 64'({32'h08070605, 4'hF, 1'b1}));
    check("t1_cnt", 64'(pkt_cnt), 64'd1);

    // 2: partial last words and short packets
    base = log_q.size();
    send_pkt(5, 8'hAA, 8'h11);
    send_pkt(1, 8'h31, 8'h01);
    send_pkt(2, 8'h41, 8'h01);
    send_pkt(3, 8'h51, 8'h01);
    drain();
    check("t2_w0", 64'(log_q[base]), 64'({32'hDDCCBBAA, 4'hF, 1'b0}));
    check("t2_w1", 64'(log_q[base+1]), 64'({32'h000000EE, 4'h1, 1'b1}));
    check("t2_p1", 64'(log_q[base+2]), 64'({32'h00000031, 4'h1, 1'b1}));
    check("t2_p2", 64'(log_q[base+3]), 64'({32'h00004241, 4'h3, 1'b1}));
    check("t2_p3", 64'(log_q[base+4]), 64'({32'h00535251, 4'h7, 1'b1}));
    check("t2_cnt", 64'(pkt_cnt), 64'd5);

    // 3: sink stalls 10 cycles mid 12-byte packet
    fork
      send_pkt(12, 8'h60, 8'h01);
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t3_s_ready_low", 64'(s_ready), 64'd0);
        check("t3_s_valid_high", 64'(s_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    check("t3_cnt", 64'(pkt_cnt), 64'd6);

    // 4: busy rising mid-packet does not stall; busy between packets gates
    t0 = $time;
    fork
      send_pkt(6, 8'h80, 8'h01);
      begin
        repeat (2) @(posedge clk);
        #1 busy = 1'b1;
      end
    join
    check("t4_no_stall", 64'(($time - t0) / 10), 64'd6);
    s_valid = 1'b1;
    s_data  = 8'h77;
    s_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_gated", 64'(s_ready), 64'd0);
    end
    @(posedge clk); #1 busy = 1'b0;
    send_pkt(1, 8'h77, 8'h01);
    drain();
    check("t4_cnt", 64'(pkt_cnt), 64'd8);

    // 5: reset after two bytes of a packet
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    s_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid", 64'(m_valid), 64'd0);
    check("t5_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk); #1;
    base = log_q.size();
    send_pkt(3, 8'h11, 8'h11);
    drain();
    check("t5_word", 64'(log_q[base]), 64'({32'h00332211, 4'h7, 1'b1}));
    check("t5_cnt_after", 64'(pkt_cnt), 64'd1);

    check("all_words_seen", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
